// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I-subset control FSM: sequences fetch/decode/execute/writeback over 3-5 cycles.
// Optional MEM_READY_EN: memory states (FETCH, MEMREAD, MEMWRITE) wait for mem_ready.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pcW,
    output logic        irW,
    output logic        adrSrc,
    output logic        mem_w,
    output logic        reg_w,
    output logic [1:0]  aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  resultSrc,
    output logic [2:0]  immSrc,
    output logic [2:0]  aluCtr,
    output logic [1:0]  comCtr,
    output logic        illegal,
    output logic [3:0]  state
);
    // state    | meaning
    // FETCH    | read instr at PC, PC <- PC+4
    // DECODE   | ALUOut <- OldPC+imm, dispatch on opcode
    // MEMADR   | ALUOut <- rs1+imm
    // MEMREAD  | Data <- mem[ALUOut]
    // MEMWB    | rd <- Data
    // MEMWRITE | mem[ALUOut] <- rs2
    // EXECR    | ALUOut <- rs1 op rs2
    // ALUWB    | rd <- ALUOut
    // EXECI    | ALUOut <- rs1 op imm
    // JAL      | PC <- ALUOut, ALUOut <- OldPC+4
    // BRANCH   | compare rs1/rs2, PC <- ALUOut if taken
    // LUI      | ALUOut <- 0+imm
    // JALRADR  | ALUOut <- rs1+imm
    // TRAP     | undecodable instruction, parked until rst
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
        MEMWRITE = 4'd5, EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8, JAL = 4'd9,
        BRANCH = 4'd10, LUI = 4'd11, JALRADR = 4'd12, TRAP = 4'd13
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t      state_q, state_d;
    logic        illegal_q;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alu_ok;
    logic [2:0]  alu_op;
    logic        br_ok;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign state   = state_q;
    assign illegal = illegal_q;
    assign br_ok   = ~funct3[1];

`ifndef MEM_READY_EN
    logic unused_in;
    assign unused_in = ^{mem_ready, instr[31], instr[29:15], instr[11:7]};
`else
    logic unused_in;
    assign unused_in = ^{instr[31], instr[29:15], instr[11:7]};
`endif

    always_comb begin
        alu_ok = 1'b1;
        alu_op = ALU_ADD;
        case (funct3)
            3'b000:  alu_op = (opcode[5] & instr[30]) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            7'b0100011: immSrc = 3'b001;
            7'b1100011: immSrc = 3'b010;
            7'b1101111: immSrc = 3'b011;
            7'b0110111: immSrc = 3'b100;
            default:    immSrc = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == TRAP) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pcW       = 1'b0;
        irW       = 1'b0;
        adrSrc    = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        resultSrc = 2'b00;
        aluCtr    = ALU_ADD;
        comCtr    = 2'b00;
        case (state_q)
            FETCH: begin
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
`ifdef MEM_READY_EN
                irW     = mem_ready;
                pcW     = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
`else
                irW     = 1'b1;
                pcW     = 1'b1;
                state_d = DECODE;
`endif
            end
            DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = BRANCH;
                    7'b1101111:             state_d = JAL;
                    7'b1100111:             state_d = JALRADR;
                    7'b0110111:             state_d = LUI;
                    default:                state_d = TRAP;
                endcase
            end
            MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                state_d = opcode[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adrSrc = 1'b1;
`ifdef MEM_READY_EN
                state_d = mem_ready ? MEMWB : MEMREAD;
`else
                state_d = MEMWB;
`endif
            end
            MEMWB: begin
                resultSrc = 2'b01;
                reg_w     = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                adrSrc = 1'b1;
                mem_w  = 1'b1;
`ifdef MEM_READY_EN
                state_d = mem_ready ? FETCH : MEMWRITE;
`else
                state_d = FETCH;
`endif
            end
            EXECR, EXECI: begin
                aluSrcA = 2'b10;
                aluSrcB = (state_q == EXECI) ? 2'b01 : 2'b00;
                aluCtr  = alu_op;
                state_d = alu_ok ? ALUWB : TRAP;
            end
            ALUWB: begin
                reg_w   = 1'b1;
                state_d = FETCH;
            end
            LUI: begin
                aluSrcA = 2'b11;
                aluSrcB = 2'b01;
                state_d = ALUWB;
            end
            JALRADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                state_d = JAL;
            end
            JAL: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                pcW     = 1'b1;
                state_d = ALUWB;
            end
            BRANCH: begin
                aluSrcA = 2'b10;
                aluCtr  = ALU_SUB;
                if (br_ok) begin
                    comCtr  = {funct3[2], funct3[0]};
                    pcW     = zero;
                    state_d = FETCH;
                end else begin
                    state_d = TRAP;
                end
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
        // Reset wins over any wait: no writes, selects parked at their FETCH values.
        if (rst) begin
            pcW       = 1'b0;
            irW       = 1'b0;
            adrSrc    = 1'b0;
            mem_w     = 1'b0;
            reg_w     = 1'b0;
            aluSrcA   = 2'b00;
            aluSrcB   = 2'b10;
            resultSrc = 2'b10;
            aluCtr    = ALU_ADD;
            comCtr    = 2'b00;
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: instruction-level reference model plus per-cycle compare.
module tb_mc_ctrl;
    logic        clk = 1'b0;
    logic        rst, zero, mem_ready;
    logic [31:0] instr;
    logic        pcW, irW, adrSrc, mem_w, reg_w, illegal;
    logic [1:0]  aluSrcA, aluSrcB, resultSrc, comCtr;
    logic [2:0]  immSrc, aluCtr;
    logic [3:0]  state;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .pcW(pcW), .irW(irW), .adrSrc(adrSrc), .mem_w(mem_w), .reg_w(reg_w),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .resultSrc(resultSrc), .immSrc(immSrc),
        .aluCtr(aluCtr), .comCtr(comCtr), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcW, irW, adrSrc, mem_w, reg_w;
        logic [1:0] aluSrcA, aluSrcB, resultSrc;
        logic [2:0] immSrc, aluCtr;
        logic [1:0] comCtr;
    } ctl_t;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'h40008093;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0030A023;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_JALR = 32'h000080E7;
    localparam logic [31:0] I_LUI  = 32'h123450B7;

    int n_checks = 0;
    int n_errors = 0;
    int m_state  = -1;
    logic m_illegal = 1'b0;
    int seq[$];
    int memw_cnt = 0;
    bit mr_rand  = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] alu_code(logic [31:0] ins);
        case (ins[14:12])
            3'd0:    return (ins[5] && ins[30]) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctl_t exp_out(int st, logic [31:0] ins, logic z, logic mr, logic r);
        ctl_t e;
        logic [2:0] f3;
        f3 = ins[14:12];
        e = '0;
        case (ins[6:0])
            7'b0100011: e.immSrc = 3'd1;
            7'b1100011: e.immSrc = 3'd2;
            7'b1101111: e.immSrc = 3'd3;
            7'b0110111: e.immSrc = 3'd4;
            default:    e.immSrc = 3'd0;
        endcase
        if (r) begin
            e.aluSrcB = 2'd2; e.resultSrc = 2'd2;
            return e;
        end
        case (st)
            0: begin
                e.irW = 1'b1; e.pcW = 1'b1; e.aluSrcB = 2'd2; e.resultSrc = 2'd2;
`ifdef MEM_READY_EN
                e.irW = mr; e.pcW = mr;
`endif
            end
            1:  begin e.aluSrcA = 2'd1; e.aluSrcB = 2'd1; end
            2:  begin e.aluSrcA = 2'd2; e.aluSrcB = 2'd1; end
            3:  e.adrSrc = 1'b1;
            4:  begin e.resultSrc = 2'd1; e.reg_w = 1'b1; end
            5:  begin e.adrSrc = 1'b1; e.mem_w = 1'b1; end
            6:  begin e.aluSrcA = 2'd2; e.aluCtr = alu_code(ins); end
            7:  e.reg_w = 1'b1;
            8:  begin e.aluSrcA = 2'd2; e.aluSrcB = 2'd1; e.aluCtr = alu_code(ins); end
            9:  begin e.aluSrcA = 2'd1; e.aluSrcB = 2'd2; e.pcW = 1'b1; end
            10: begin
                e.aluSrcA = 2'd2; e.aluCtr = 3'b001;
                if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) begin
                    e.comCtr = {f3[2], f3[0]};
                    e.pcW = z;
                end
            end
            11: begin e.aluSrcA = 2'd3; e.aluSrcB = 2'd1; end
            12: begin e.aluSrcA = 2'd2; e.aluSrcB = 2'd1; end
            default: ;
        endcase
        return e;
    endfunction

    // Whole state path of one instruction after its FETCH, ending at FETCH or TRAP.
    task automatic build_seq(logic [31:0] ins);
        logic [2:0] f3;
        bit alu_ok, br_ok;
        f3 = ins[14:12];
        alu_ok = (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
        br_ok  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5);
        case (ins[6:0])
            7'b0000011: seq = '{1, 2, 3, 4, 0};
            7'b0100011: seq = '{1, 2, 5, 0};
            7'b0110011: if (alu_ok) seq = '{1, 6, 7, 0}; else seq = '{1, 6, 13};
            7'b0010011: if (alu_ok) seq = '{1, 8, 7, 0}; else seq = '{1, 8, 13};
            7'b1100011: if (br_ok) seq = '{1, 10, 0}; else seq = '{1, 10, 13};
            7'b1101111: seq = '{1, 9, 7, 0};
            7'b1100111: seq = '{1, 12, 9, 7, 0};
            7'b0110111: seq = '{1, 11, 7, 0};
            default:    seq = '{1, 13};
        endcase
    endtask

    task automatic model_advance();
        if (rst) begin
            m_state = 0; m_illegal = 1'b0; seq.delete();
        end else if (m_state == 13 || m_state < 0) begin
        end
`ifdef MEM_READY_EN
        else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
        end
`endif
        else begin
            if (m_state == 0) build_seq(instr);
            m_state = seq.pop_front();
            if (m_state == 13) m_illegal = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    always @(negedge clk) begin
        ctl_t e, a;
        e = exp_out(m_state, instr, zero, mem_ready, rst);
        a = {pcW, irW, adrSrc, mem_w, reg_w, aluSrcA, aluSrcB, resultSrc, immSrc, aluCtr, comCtr};
        chk($sformatf("ctl st=%0d instr=%h", m_state, instr), a, e);
        if (m_state >= 0) begin
            chk("state", state, m_state);
            chk("illegal", illegal, m_illegal);
        end
        if (mem_w) memw_cnt++;
    end

    task automatic run_instr(logic [31:0] ins, int zm, output int cyc);
        bit gone, done;
        gone = 1'b0; done = 1'b0; cyc = 0;
        instr = ins;
        for (int i = 0; i < 80; i++) begin
            zero = (zm == 2) ? 1'($urandom % 2) : zm[0];
`ifdef MEM_READY_EN
            mem_ready = mr_rand ? ($urandom % 4 != 0) : 1'b1;
`else
            mem_ready = 1'($urandom % 2);
`endif
            step();
            cyc++;
            if (m_state != 0) gone = 1'b1;
            if (m_state == 13 || (gone && m_state == 0)) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("instr_timeout", 32'd1, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0] f3;
        r = $urandom;
        case ($urandom % 4)
            0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd6; default: f3 = 3'd7;
        endcase
        case ($urandom_range(0, 7))
            0: begin r[6:0] = 7'b0000011; r[14:12] = 3'd2; end
            1: begin r[6:0] = 7'b0100011; r[14:12] = 3'd2; end
            2: begin r[6:0] = 7'b0110011; r[14:12] = f3; r[31:25] = ($urandom % 2) ? 7'h20 : 7'h00; end
            3: begin r[6:0] = 7'b0010011; r[14:12] = f3; end
            4: begin r[6:0] = 7'b1100011; r[14:12] = {1'($urandom % 2), 1'b0, 1'($urandom % 2)}; end
            5: r[6:0] = 7'b1101111;
            6: begin r[6:0] = 7'b1100111; r[14:12] = 3'd0; end
            default: r[6:0] = 7'b0110111;
        endcase
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        rst = 1'b1; instr = I_ADD; zero = 1'b0; mem_ready = 1'b1;
        step();
        chk("rst_state", state, 0);
        chk("rst_irW", irW, 0);
        chk("rst_pcW", pcW, 0);
        step(); step();
        rst = 1'b0; #1;
        chk("add_c1_state", state, 0);
        chk("add_c1_irW", irW, 1);
        step(); chk("add_c2_state", state, 1);
        step(); chk("add_c3_state", state, 6); chk("add_c3_aluCtr", aluCtr, 0); chk("add_c3_reg_w", reg_w, 0);
        step(); chk("add_c4_state", state, 7); chk("add_c4_reg_w", reg_w, 1);
        step(); chk("add_c5_state", state, 0);

        chk("model_sub_code", alu_code(I_SUB), 3'b001);
        chk("model_addi_code", alu_code(I_ADDI), 3'b000);
        run_instr(I_SUB, 2, c);
        run_instr(I_ADDI, 2, c);
        run_instr(I_LW, 2, c);
`ifndef MEM_READY_EN
        chk("cpi_lw", c, 5);
`endif
        memw_cnt = 0;
        run_instr(I_SW, 2, c);
        chk("sw_memw_cycles", memw_cnt, 1);

        instr = I_BNE; zero = 1'b1; mem_ready = 1'b1;
        step(); step();
        chk("bne_z1_state", state, 10); chk("bne_z1_pcW", pcW, 1); chk("bne_z1_comCtr", comCtr, 2'b01);
        step(); chk("bne_z1_back", state, 0);
        zero = 1'b0;
        step(); step();
        chk("bne_z0_pcW", pcW, 0);
        step(); chk("bne_z0_back", state, 0);

        run_instr(I_JALR, 2, c);
`ifndef MEM_READY_EN
        chk("cpi_jalr", c, 5);
`endif
        run_instr(I_JAL, 2, c);
        run_instr(I_LUI, 2, c);
`ifndef MEM_READY_EN
        chk("cpi_lui", c, 4);
`endif

`ifdef MEM_READY_EN
        instr = I_ADD; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("stall_irW", irW, 0); chk("stall_pcW", pcW, 0);
            step();
        end
        mem_ready = 1'b1; #1;
        chk("stall_release_irW", irW, 1);
        repeat (4) step();
        chk("stall_add_done", state, 0);
`endif

        // Reset landing in the middle of a store must suppress the write.
        instr = I_SW; mem_ready = 1'b1;
        step(); step(); step();
        chk("sw_in_memwrite", state, 5);
`ifdef MEM_READY_EN
        mem_ready = 1'b0; step();
`endif
        rst = 1'b1; #1;
        chk("rst_mid_mem_w", mem_w, 0);
        step(); rst = 1'b0; #1;
        chk("rst_mid_state", state, 0);

        mr_rand = 1'b1;
        repeat (300) run_instr(rand_instr(), 2, c);
        mr_rand = 1'b0;

        run_instr(32'h0000007F, 2, c);
        chk("trap_state", state, 13);
        chk("trap_illegal", illegal, 1);
        repeat (20) step();
        chk("trap_hold_illegal", illegal, 1);
        rst = 1'b1; step(); rst = 1'b0; #1;
        chk("trap_cleared", illegal, 0);

        run_instr(32'h002091B3, 2, c);
        chk("bad_alu_trap", state, 13);
        rst = 1'b1; step(); rst = 1'b0; #1;
        run_instr(32'h0020A063, 2, c);
        chk("bad_branch_trap", state, 13);
        rst = 1'b1; step(); rst = 1'b0; #1;
        chk("final_state", state, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
